// File: rtl/pack_n_to_vector.sv
// Serial-to-parallel packer: gathers NUM_INPUTS samples into one lane vector
// and issues it with a one-cycle valid; i_flush emits a zero-padded partial frame.
module pack_n_to_vector #(
  parameter int NUM_INPUTS = 16,
  parameter int DWIDTH     = 16,
  localparam int CWIDTH    = $clog2(NUM_INPUTS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DWIDTH-1:0]            i_dat,
  input  logic                         i_dat_valid,
  input  logic                         i_flush,
  output logic [NUM_INPUTS*DWIDTH-1:0] o_dat_vector,
  output logic                         o_dat_valid,
  output logic [CWIDTH-1:0]            o_dat_count,
  output logic [CWIDTH-1:0]            o_fill
);

  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  // Handshake: valid-only stream, no ready. A sample is taken on every edge where
  // i_dat_valid is high; o_dat_valid pulses for one cycle and downstream must take it.

  logic [DWIDTH-1:0]            lanes_q [NUM_INPUTS];
  logic [DWIDTH-1:0]            lanes_d [NUM_INPUTS];
  logic [DWIDTH-1:0]            lanes_w [NUM_INPUTS];
  logic [CWIDTH-1:0]            fill_q, fill_d, fill_after;
  logic [NUM_INPUTS*DWIDTH-1:0] vec_q, vec_d, vec_pack;
  logic [CWIDTH-1:0]            count_q, count_d;
  logic                         valid_q, valid_d;
  logic                         full, emit;
  logic [IW-1:0]                wr_idx;

  assign wr_idx     = fill_q[IW-1:0];
  assign fill_after = fill_q + CWIDTH'(i_dat_valid);
  assign full       = i_dat_valid && (fill_q == CWIDTH'(NUM_INPUTS - 1));
  // A flush sees the frame after any same-edge accept, so a completing sample plus
  // flush yields one full frame and never an extra empty one.
  assign emit       = full || (i_flush && (fill_after != '0));

  always_comb begin
    for (int k = 0; k < NUM_INPUTS; k++) begin
      lanes_w[k] = lanes_q[k];
    end
    if (i_dat_valid) begin
      lanes_w[wr_idx] = i_dat;
    end
  end

  always_comb begin
    vec_pack = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      vec_pack[k*DWIDTH +: DWIDTH] = lanes_w[k];
    end
  end

  always_comb begin
    valid_d = emit;
    vec_d   = vec_q;
    count_d = count_q;
    fill_d  = fill_after;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      lanes_d[k] = lanes_w[k];
    end
    if (emit) begin
      // Unused lanes are already zero because the working set is cleared on emit.
      vec_d   = vec_pack;
      count_d = fill_after;
      fill_d  = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
        lanes_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        lanes_q[k] <= '0;
      end
      fill_q  <= '0;
      vec_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        lanes_q[k] <= lanes_d[k];
      end
      fill_q  <= fill_d;
      vec_q   <= vec_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign o_dat_vector = vec_q;
  assign o_dat_valid  = valid_q;
  assign o_dat_count  = count_q;
  assign o_fill       = fill_q;

endmodule

// File: tb/tb_pack_n_to_vector.sv
// Bench for pack_n_to_vector: directed + random samples against a queue-based
// frame model; each edge checks pulse, frame contents, held output and fill.
module tb_pack_n_to_vector;

  localparam int N  = 16;
  localparam int W  = 16;
  localparam int CW = $clog2(N + 1);
  localparam int VW = N * W;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  i_dat;
  logic          i_dat_valid;
  logic          i_flush;
  logic [VW-1:0] o_dat_vector;
  logic          o_dat_valid;
  logic [CW-1:0] o_dat_count;
  logic [CW-1:0] o_fill;

  pack_n_to_vector #(.NUM_INPUTS(N), .DWIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_dat        (i_dat),
    .i_dat_valid  (i_dat_valid),
    .i_flush      (i_flush),
    .o_dat_vector (o_dat_vector),
    .o_dat_valid  (o_dat_valid),
    .o_dat_count  (o_dat_count),
    .o_fill       (o_fill)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard and model state
  logic [W-1:0]  pend[$];
  logic [VW-1:0] exp_q[$];
  int            cnt_q[$];
  int            pulse_cyc[$];
  logic [VW-1:0] last_vec;
  logic [VW-1:0] g_ref;
  int            n_cmp;
  int            n_bad;
  int            cyc;
  int            pulses;
  bit            avg_on;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] frame_of(input int nsamp);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      if (k < nsamp) v[k*W +: W] = pend[k];
    end
    return v;
  endfunction

  function automatic int lane_sum(input logic [VW-1:0] v);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += int'(v[k*W +: W]);
    return s;
  endfunction

  // driver: one clock edge with the given inputs, then model update and checks
  task automatic step(input logic v, input logic [W-1:0] d, input logic f);
    logic [VW-1:0] ev;
    int            ec;
    int            a_obs;
    int            a_exp;
    i_dat_valid = v;
    i_dat       = d;
    i_flush     = f;
    @(posedge clk);
    if (v) pend.push_back(d);
    if (pend.size() == N || (f && pend.size() > 0)) begin
      exp_q.push_back(frame_of(pend.size()));
      cnt_q.push_back(pend.size());
      pend.delete();
    end
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      ec = cnt_q.pop_front();
      check("valid_pulse", VW'(o_dat_valid), VW'(1));
      check("vector", o_dat_vector, ev);
      check("count", VW'(o_dat_count), VW'(ec));
      last_vec = ev;
      pulses++;
      pulse_cyc.push_back(cyc);
      if (avg_on) begin
        a_obs = lane_sum(o_dat_vector) / N;
        a_exp = lane_sum(ev) / N;
        n_cmp++;
        assert (a_obs == a_exp || a_obs == a_exp + 1) else begin
          n_bad++;
          $error("FAIL average observed=%0d expected=%0d", a_obs, a_exp);
        end
      end
    end else begin
      check("valid_idle", VW'(o_dat_valid), VW'(0));
      check("vector_hold", o_dat_vector, last_vec);
    end
    check("fill", VW'(o_fill), VW'(pend.size()));
    i_dat_valid = 1'b0;
    i_flush     = 1'b0;
  endtask

  // asynchronous reset asserted between edges, held through one edge
  task automatic do_reset();
    i_dat_valid = 1'b0;
    i_flush     = 1'b0;
    rst_n       = 1'b0;
    #2;
    check("rst_valid", VW'(o_dat_valid), VW'(0));
    check("rst_fill", VW'(o_fill), VW'(0));
    check("rst_vector", o_dat_vector, '0);
    check("rst_count", VW'(o_dat_count), VW'(0));
    pend.delete();
    exp_q.delete();
    cnt_q.delete();
    last_vec = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int p0;
    n_cmp = 0; n_bad = 0; cyc = 0; pulses = 0; avg_on = 1'b0;
    last_vec = '0;
    rst_n = 1'b0; i_dat = '0; i_dat_valid = 1'b0; i_flush = 1'b0;
    #3;
    check("rst_valid", VW'(o_dat_valid), VW'(0));
    check("rst_fill", VW'(o_fill), VW'(0));
    check("rst_vector", o_dat_vector, '0);
    check("rst_count", VW'(o_dat_count), VW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 16 consecutive samples 1..16
    for (int i = 1; i <= N; i++) step(1'b1, W'(i), 1'b0);
    check("t1_lane0", VW'(o_dat_vector[0 +: W]), VW'(16'h0001));
    check("t1_lane15", VW'(o_dat_vector[15*W +: W]), VW'(16'h0010));
    g_ref = o_dat_vector;
    step(1'b0, '0, 1'b0);

    // 48 back-to-back random samples
    p0 = pulses;
    for (int i = 0; i < 3 * N; i++) step(1'b1, W'($urandom), 1'b0);
    check("t2_pulses", VW'(pulses - p0), VW'(3));
    check("t2_gap_a", VW'(pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2]), VW'(N));
    check("t2_gap_b", VW'(pulse_cyc[pulse_cyc.size()-2] - pulse_cyc[pulse_cyc.size()-3]), VW'(N));
    for (int i = 0; i < 5; i++) step(1'b0, W'($urandom), 1'b0);

    // same 1..16 data with random idle gaps
    p0 = pulses;
    for (int i = 1; i <= N; i++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) step(1'b0, W'($urandom), 1'b0);
      step(1'b1, W'(i), 1'b0);
    end
    check("t3_pulses", VW'(pulses - p0), VW'(1));
    check("t3_same", o_dat_vector, g_ref);

    // 5 samples then flush alone
    for (int i = 0; i < 5; i++) step(1'b1, W'(16'h00A0 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    check("t4_count", VW'(o_dat_count), VW'(5));
    check("t4_lane4", VW'(o_dat_vector[4*W +: W]), VW'(16'h00A4));
    check("t4_lane5", VW'(o_dat_vector[5*W +: W]), VW'(0));

    // flush with nothing held
    p0 = pulses;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    check("t5_no_pulse", VW'(pulses - p0), VW'(0));

    // flush together with the completing sample
    p0 = pulses;
    for (int i = 0; i < N - 1; i++) step(1'b1, W'($urandom), 1'b0);
    step(1'b1, W'($urandom), 1'b1);
    step(1'b0, '0, 1'b0);
    check("t6_one_pulse", VW'(pulses - p0), VW'(1));
    check("t6_count", VW'(o_dat_count), VW'(N));

    // flush together with a non-completing sample
    for (int i = 0; i < 2; i++) step(1'b1, W'($urandom), 1'b0);
    step(1'b1, W'($urandom), 1'b1);

    // reset mid-frame discards the partial frame
    for (int i = 0; i < 7; i++) step(1'b1, W'($urandom), 1'b0);
    do_reset();
    for (int i = 0; i < N; i++) step(1'b1, W'(16'h0100 + i), 1'b0);
    check("t7_lane0", VW'(o_dat_vector[0 +: W]), VW'(16'h0100));
    check("t7_lane15", VW'(o_dat_vector[15*W +: W]), VW'(16'h010F));

    // 40 random frames with occasional idle cycles, checking block averages
    avg_on = 1'b1;
    p0 = pulses;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) step(1'b0, W'($urandom), 1'b0);
        step(1'b1, W'($urandom), 1'b0);
      end
    end
    avg_on = 1'b0;
    check("t8_pulses", VW'(pulses - p0), VW'(40));
    check("sb_empty", VW'(exp_q.size()), VW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pack_n_to_vector.md
# pack_n_to_vector

Serial-to-parallel packer that collects NUM_INPUTS samples, arriving one per clock under a valid strobe, into one wide lane vector. It then issues that vector with a single-cycle valid. It sits directly upstream of the N-per-clock averager and drives its vector/valid input so a one-sample-per-clock stream can be averaged in blocks. A flush input emits partially filled frames at end of stream.

## Interface
- NUM_INPUTS, 16, lanes per output frame; must be ≥ 2.
- DWIDTH, 16, bits per sample/lane.
- CWIDTH, $clog2(NUM_INPUTS+1), width of the count outputs (derived, not overridden).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- i_dat  in  DWIDTH  input sample.
- i_dat_valid  in  1  i_dat accepted on this edge when high.
- i_flush  in  1  emit the current partial frame (zero-padded) on this edge.
- o_dat_vector  out  NUM_INPUTS*DWIDTH  packed frame; lane k = bits [DWIDTH*k +: DWIDTH].
- o_dat_valid  out  1  one-cycle pulse; o_dat_vector is new this cycle.
- o_dat_count  out  CWIDTH  number of real samples in the emitted frame (1..NUM_INPUTS).
- o_fill  out  CWIDTH  samples currently held in the working buffer (0..NUM_INPUTS-1).

## Operation
- Two storage sets:
  - Working buffer: NUM_INPUTS lanes plus fill counter.
  - Output register: o_dat_vector and o_dat_count.
- Collection continues back-to-back while the output register holds the previous frame.
- Accept: when i_dat_valid=1, i_dat is written to working lane o_fill, and o_fill increments.
- Full frame: when the accepted sample lands in lane NUM_INPUTS-1, on the same edge:
  - working lanes plus the new sample are copied to o_dat_vector;
  - o_dat_count ← NUM_INPUTS;
  - o_dat_valid ← 1;
  - o_fill ← 0;
  - working lanes are cleared to 0.
- Flush: when i_flush=1, the working frame is emitted on that edge if the fill after any same-edge accept is ≥ 1.
  - Lanes ≥ count are 0.
  - o_dat_count = count.
  - o_fill ← 0; working lanes cleared.
- Flush with fill 0 and no valid: no emission, no state change.
- Simultaneous valid + flush:
  - The sample is included first.
  - If it completes the frame, exactly one full frame is emitted (count NUM_INPUTS), not an extra empty one.
- Gaps in i_dat_valid do not reset collection. The frame waits indefinitely.
- o_dat_valid is high for exactly one cycle per emitted frame.
- o_dat_vector and o_dat_count hold their values until the next emission.
- There is no back-pressure. The downstream block accepts every cycle.
- Datapath is pure transport: no arithmetic on samples, bit-exact lane placement.
- Counters are sized CWIDTH. o_fill never reaches NUM_INPUTS, so it cannot wrap.

## Timing
- Reset (rst_n=0, asynchronous), all cleared immediately:
  - o_dat_valid=0
  - o_dat_vector=0
  - o_dat_count=0
  - o_fill=0
  - working lanes=0
- Reset mid-frame discards the partial frame with no emission.
- Deassertion is sampled by clk. The first edge with rst_n=1 may accept a sample.
- Latency: o_dat_valid rises on the clock edge that accepts the last sample (or flush). It is visible the cycle after that sample was presented, i.e. 1 cycle.
- Back-to-back full-rate input gives one o_dat_valid pulse every NUM_INPUTS cycles, with no dead cycles.
- o_fill is registered. It reflects samples accepted up to and including the previous edge.

## Test plan
- Reset, then 16 consecutive samples 0x0001..0x0010 (NUM_INPUTS=16, DWIDTH=16):
  - one o_dat_valid pulse, one cycle after the 16th sample;
  - lane0=0x0001, lane15=0x0010, o_dat_count=16, o_fill=0.
- 48 back-to-back random samples:
  - exactly 3 pulses, 16 cycles apart;
  - each frame matches the scoreboard lane-for-lane;
  - vector stable between pulses.
- 16 samples with random 0–3 cycle gaps in valid:
  - single frame, identical content to the gapless case;
  - o_fill increments only on valid edges.
- 5 samples 0xA0..0xA4, then i_flush alone:
  - pulse with o_dat_count=5, lanes0–4 = 0xA0..0xA4, lanes5–15 = 0.
- i_flush alone with o_fill=0 produces no pulse.
- i_flush together with the 16th valid sample produces exactly one pulse with count 16.
- 7 samples, rst_n low 1 cycle mid-clock, then 16 samples 0x100..0x10F:
  - o_fill=0 and o_dat_valid=0 immediately during reset;
  - next frame contains only 0x100..0x10F.
- Stream into the averager over 40 random frames: every average matches the floor of sum/16, or that value +1.
